// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter tracking monitor.
package counter_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_EXT_W = 4;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } trk_state_e;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_BAD  = 2'd3
    } step_e;

endpackage

// File: rtl/counter_step_classify.sv
// Combinational classifier: decides whether a new counter sample is a hold,
// a legal up/down step, or a protocol violation.
module counter_step_classify
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             ovf_in,
    input  logic             act_in,
    output step_e            step
);

    localparam logic [WIDTH-1:0] MAX    = '1;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam bit               NARROW = (WIDTH == 1);

    logic [WIDTH-1:0] delta;
    assign delta = cnt_in - prev;

    // Delta/overflow rules; a 1-bit counter is classified by ovf_in and prev only
    always_comb begin
        step = STEP_BAD;
        if (delta == '0) begin
            step = ovf_in ? STEP_BAD : STEP_HOLD;
        end else if (!act_in) begin
            step = STEP_BAD;
        end else if (NARROW) begin
            if (ovf_in) step = (prev == MAX) ? STEP_UP : STEP_DOWN;
        end else if (delta == ONE) begin
            if (ovf_in == (prev == MAX)) step = STEP_UP;
        end else if (delta == MAX) begin
            if (ovf_in == (prev == '0)) step = STEP_DOWN;
        end
    end

endmodule

// File: rtl/counter_tracker.sv
// Monitor/extender for an up/down counter: follows its count, rebuilds a
// wider count and flags any break of the count/overflow contract.
module counter_tracker
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned EXT_W = DEF_EXT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   src_rst_n,
    input  logic                   act_in,
    input  logic [WIDTH-1:0]       cnt_in,
    input  logic                   ovf_in,
    input  logic                   clr_err,
    output logic [WIDTH+EXT_W-1:0] ext_count,
    output logic                   dir,
    output logic                   step_vld,
    output logic                   err,
    output logic                   err_sticky,
    output logic                   ext_ovf,
    output logic [1:0]             state
);

    localparam int unsigned XW = WIDTH + EXT_W;

    trk_state_e       state_q, state_nxt;
    logic [WIDTH-1:0] prev_q, prev_nxt;
    logic [XW-1:0]    ext_nxt;
    logic             dir_nxt, step_nxt, err_nxt, sticky_nxt, ext_ovf_nxt;
    step_e            step_c;

    counter_step_classify #(.WIDTH(WIDTH)) u_classify (
        .prev   (prev_q),
        .cnt_in (cnt_in),
        .ovf_in (ovf_in),
        .act_in (act_in),
        .step   (step_c)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SYNC;
        else     state_q <= state_nxt;
    end

    // Next state and next values of every registered output
    always_comb begin
        state_nxt   = state_q;
        prev_nxt    = prev_q;
        ext_nxt     = ext_count;
        dir_nxt     = dir;
        step_nxt    = 1'b0;
        err_nxt     = 1'b0;
        sticky_nxt  = err_sticky;
        ext_ovf_nxt = ext_ovf;
        if (!src_rst_n) begin
            state_nxt = SYNC;
            ext_nxt   = '0;
            prev_nxt  = '0;
        end else begin
            unique case (state_q)
                SYNC: begin
                    prev_nxt  = cnt_in;
                    ext_nxt   = XW'(cnt_in);
                    state_nxt = TRACK;
                end
                TRACK: begin
                    prev_nxt = cnt_in;
                    unique case (step_c)
                        STEP_UP: begin
                            ext_nxt  = ext_count + XW'(1);
                            dir_nxt  = 1'b1;
                            step_nxt = 1'b1;
                            if (ext_count == '1) ext_ovf_nxt = 1'b1;
                        end
                        STEP_DOWN: begin
                            ext_nxt  = ext_count - XW'(1);
                            dir_nxt  = 1'b0;
                            step_nxt = 1'b1;
                            if (ext_count == '0) ext_ovf_nxt = 1'b1;
                        end
                        STEP_BAD: begin
                            err_nxt    = 1'b1;
                            sticky_nxt = 1'b1;
                            state_nxt  = ERROR;
                        end
                        default: ;
                    endcase
                end
                ERROR: begin
                    if (clr_err) state_nxt = SYNC;
                end
                default: state_nxt = SYNC;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            ext_count  <= '0;
            dir        <= 1'b1;
            step_vld   <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            ext_ovf    <= 1'b0;
        end else begin
            prev_q     <= prev_nxt;
            ext_count  <= ext_nxt;
            dir        <= dir_nxt;
            step_vld   <= step_nxt;
            err        <= err_nxt;
            err_sticky <= sticky_nxt;
            ext_ovf    <= ext_ovf_nxt;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_counter_tracker.sv
// Directed self-checking bench for counter_tracker (WIDTH=4, EXT_W=4).
module tb_counter_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       src_rst_n;
    logic       act_in;
    logic [3:0] cnt_in;
    logic       ovf_in;
    logic       clr_err;
    logic [7:0] ext_count;
    logic       dir;
    logic       step_vld;
    logic       err;
    logic       err_sticky;
    logic       ext_ovf;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    counter_tracker #(.WIDTH(4), .EXT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_rst_n  (src_rst_n),
        .act_in     (act_in),
        .cnt_in     (cnt_in),
        .ovf_in     (ovf_in),
        .clr_err    (clr_err),
        .ext_count  (ext_count),
        .dir        (dir),
        .step_vld   (step_vld),
        .err        (err),
        .err_sticky (err_sticky),
        .ext_ovf    (ext_ovf),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it differs
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one sample and let it be clocked in; outputs are read 1 time unit later
    task automatic drive(input logic s, input logic a, input logic [3:0] c,
                         input logic o, input logic clr);
        src_rst_n = s;
        act_in    = a;
        cnt_in    = c;
        ovf_in    = o;
        clr_err   = clr;
        @(posedge clk);
        #1;
    endtask

    // Resynchronise through a counter reset and land in TRACK at value c
    task automatic resync(input logic [3:0] c);
        drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, c, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; src_rst_n = 1'b0; act_in = 1'b0; cnt_in = '0; ovf_in = 1'b0; clr_err = 1'b0;
        #12;
        check("rst_ext", 32'(ext_count), 0);
        check("rst_dir", 32'(dir), 1);
        check("rst_step", 32'(step_vld), 0);
        check("rst_err", 32'(err), 0);
        check("rst_sticky", 32'(err_sticky), 0);
        check("rst_extovf", 32'(ext_ovf), 0);
        check("rst_state", 32'(state), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        check("sync_state", 32'(state), 1);
        check("sync_nostep", 32'(step_vld), 0);

        // 1: up-count 0..15 then wrap with overflow
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b1, 4'(i), i == 16, 1'b0);
            check("up_ext", 32'(ext_count), 32'(i));
            check("up_step", 32'(step_vld), 1);
            check("up_err", 32'(err), 0);
        end

        // 2: down wrap 0->15 with overflow, then two plain down steps
        drive(1'b1, 1'b1, 4'd15, 1'b1, 1'b0);
        check("dn_wrap_ext", 32'(ext_count), 15);
        check("dn_wrap_dir", 32'(dir), 0);
        drive(1'b1, 1'b1, 4'd14, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'd13, 1'b0, 1'b0);
        check("dn_ext", 32'(ext_count), 13);
        check("dn_step", 32'(step_vld), 1);

        // 3: jump 3->6, then clear and resync
        resync(4'd3);
        check("j_sync_ext", 32'(ext_count), 3);
        drive(1'b1, 1'b1, 4'd6, 1'b0, 1'b0);
        check("j_err", 32'(err), 1);
        check("j_sticky", 32'(err_sticky), 1);
        check("j_state", 32'(state), 2);
        check("j_ext_hold", 32'(ext_count), 3);
        check("j_nostep", 32'(step_vld), 0);
        drive(1'b1, 1'b1, 4'd6, 1'b0, 1'b0);
        check("j_err_pulse", 32'(err), 0);
        check("j_still_err", 32'(state), 2);
        drive(1'b1, 1'b1, 4'd9, 1'b0, 1'b1);
        check("clr_state", 32'(state), 0);
        check("clr_ext", 32'(ext_count), 3);
        drive(1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
        check("resync_state", 32'(state), 1);
        check("resync_ext", 32'(ext_count), 9);
        check("sticky_keeps", 32'(err_sticky), 1);

        // 4a: wrap 15->0 without overflow
        resync(4'd15);
        drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        check("noovf_err", 32'(err), 1);
        check("noovf_ext", 32'(ext_count), 15);
        // 4b: overflow on a hold
        drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
        check("h_sync_ext", 32'(ext_count), 5);
        drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
        check("holdovf_err", 32'(err), 1);
        check("holdovf_state", 32'(state), 2);
        // 4c: overflow on an up step away from MAX
        resync(4'd4);
        drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
        check("spur_ovf_err", 32'(err), 1);

        // 5: inactive counter
        resync(4'd7);
        drive(1'b1, 1'b0, 4'd7, 1'b0, 1'b0);
        check("idle_err", 32'(err), 0);
        check("idle_step", 32'(step_vld), 0);
        check("idle_state", 32'(state), 1);
        drive(1'b1, 1'b0, 4'd8, 1'b0, 1'b0);
        check("inact_err", 32'(err), 1);

        // Simultaneous events: src reset beats a violation; clr_err in TRACK ignored
        resync(4'd2);
        drive(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        check("srst_noerr", 32'(err), 0);
        check("srst_state", 32'(state), 0);
        check("srst_ext", 32'(ext_count), 0);
        drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
        check("clr_trk_state", 32'(state), 1);
        check("clr_trk_ext", 32'(ext_count), 3);

        // 6: extended count wraps 255 -> 0
        resync(4'd0);
        for (int i = 1; i <= 255; i++)
            drive(1'b1, 1'b1, 4'(i), 4'(i) == 4'd0, 1'b0);
        check("ext255", 32'(ext_count), 255);
        check("ext255_ovf", 32'(ext_ovf), 0);
        drive(1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
        check("extwrap_ext", 32'(ext_count), 0);
        check("extwrap_ovf", 32'(ext_ovf), 1);
        drive(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
        check("pre_rst_ext", 32'(ext_count), 2);

        // Async reset mid-count takes effect without a clock edge
        #2;
        rst = 1'b1;
        #1;
        check("arst_ext", 32'(ext_count), 0);
        check("arst_state", 32'(state), 0);
        check("arst_extovf", 32'(ext_ovf), 0);
        check("arst_sticky", 32'(err_sticky), 0);
        check("arst_dir", 32'(dir), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
